fetch_redirect_arbiter: RTL and testbench

FETCH_REDIRECT_ARBITER -- requirements
Module: fetch_redirect_arbiter

---
 rtl/fetch_redirect_arbiter_pkg.sv | 26 ++
 rtl/fetch_redirect_arbiter_prio_sel.sv | 41 ++++
 rtl/fetch_redirect_arbiter.sv | 169 ++++++++++++++++
 tb/tb_fetch_redirect_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_redirect_arbiter_pkg.sv
// Shared types and constants for the fetch redirect arbiter.
//   redirect_state_t : arbiter FSM states
//   redirect_prio_t  : request priority, lower value wins
//   PRIO_*           : fixed priority of each redirect source
package fetch_redirect_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      HOLD  = 2'd1,
      FLUSH = 2'd2
   } redirect_state_t;

   typedef logic [1:0] redirect_prio_t;

   localparam redirect_prio_t PRIO_EXC     = 2'd0;
   localparam redirect_prio_t PRIO_MISPRED = 2'd1;
   localparam redirect_prio_t PRIO_PRED    = 2'd2;

   localparam int CNT_W = 3;

   // True when request priority a strictly outranks b.
   function automatic logic prio_beats(input redirect_prio_t a, input redirect_prio_t b);
      return a < b;
   endfunction

endpackage

// File: rtl/fetch_redirect_arbiter_prio_sel.sv
// redirect_prio_sel: combinational fixed-priority selector.
//   exc_*_i     : exception redirect (highest)
//   mispred_*_i : branch misprediction redirect
//   pred_*_i    : predicted-taken redirect (lowest)
//   sel_*_o     : winning request valid / pc / priority
module redirect_prio_sel
   import fetch_redirect_arbiter_pkg::*;
#(
   parameter int PC_W = 32
) (
   input  logic            exc_valid_i,
   input  logic [PC_W-1:0] exc_pc_i,
   input  logic            mispred_valid_i,
   input  logic [PC_W-1:0] mispred_pc_i,
   input  logic            pred_valid_i,
   input  logic [PC_W-1:0] pred_pc_i,
   output logic            sel_valid_o,
   output logic [PC_W-1:0] sel_pc_o,
   output redirect_prio_t  sel_prio_o
);

   always_comb begin
      sel_valid_o = 1'b0;
      sel_pc_o    = '0;
      sel_prio_o  = PRIO_PRED;
      if (exc_valid_i) begin
         sel_valid_o = 1'b1;
         sel_pc_o    = exc_pc_i;
         sel_prio_o  = PRIO_EXC;
      end else if (mispred_valid_i) begin
         sel_valid_o = 1'b1;
         sel_pc_o    = mispred_pc_i;
         sel_prio_o  = PRIO_MISPRED;
      end else if (pred_valid_i) begin
         sel_valid_o = 1'b1;
         sel_pc_o    = pred_pc_i;
         sel_prio_o  = PRIO_PRED;
      end
   end

endmodule

// File: rtl/fetch_redirect_arbiter.sv
// fetch_redirect_arbiter: arbitrates exception / mispredict / predicted
// redirects onto the fetch PC load port, parks a redirect while the icache
// is busy, and squashes IF/ID for FLUSH_CYCLES after every issued redirect.
//   clk, rst_n            : clock, synchronous active-low reset
//   exc_*, mispred_*, pred_* : redirect requests (valid/pc)
//   icache_busy           : fetch cannot take a PC change this cycle
//   hz_stall              : hazard-unit stall request
//   load_we/load_pc       : fetch PC load (word aligned)
//   stall, flush, pending : fetch hold, IF/ID squash, redirect parked
// Optional build macro REDIRECT_PERF_EN adds redirect_cnt / drop_cnt.
//
// state | meaning
// IDLE  | no redirect outstanding
// HOLD  | redirect parked, waiting for icache_busy to drop
// FLUSH | squashing wrong-path IF/ID, counter running
module fetch_redirect_arbiter
   import fetch_redirect_arbiter_pkg::*;
#(
   parameter int FLUSH_CYCLES = 1,
   parameter int PC_W         = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            exc_valid,
   input  logic [PC_W-1:0] exc_pc,
   input  logic            mispred_valid,
   input  logic [PC_W-1:0] mispred_pc,
   input  logic            pred_valid,
   input  logic [PC_W-1:0] pred_pc,
   input  logic            icache_busy,
   input  logic            hz_stall,
`ifdef REDIRECT_PERF_EN
   output logic [31:0]     redirect_cnt,
   output logic [31:0]     drop_cnt,
`endif
   output logic            load_we,
   output logic [PC_W-1:0] load_pc,
   output logic            stall,
   output logic            flush,
   output logic            pending
);

   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(FLUSH_CYCLES);

   redirect_state_t  state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [PC_W-1:0]  pend_pc_q, pend_pc_d;
   redirect_prio_t   pend_prio_q, pend_prio_d;

   logic             pred_eff;
   logic             sel_valid;
   logic [PC_W-1:0]  sel_pc;
   redirect_prio_t   sel_prio;
   logic             issue;
   logic [PC_W-1:0]  issue_pc;
   logic             take_new;

   // Predicted-taken redirects are meaningless while squashing.
   assign pred_eff = pred_valid & (state_q != FLUSH);

   redirect_prio_sel #(.PC_W(PC_W)) u_sel (
      .exc_valid_i     (exc_valid),
      .exc_pc_i        (exc_pc),
      .mispred_valid_i (mispred_valid),
      .mispred_pc_i    (mispred_pc),
      .pred_valid_i    (pred_eff),
      .pred_pc_i       (pred_pc),
      .sel_valid_o     (sel_valid),
      .sel_pc_o        (sel_pc),
      .sel_prio_o      (sel_prio)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      pend_pc_d   = pend_pc_q;
      pend_prio_d = pend_prio_q;
      issue       = 1'b0;
      issue_pc    = sel_pc;
      take_new    = 1'b0;

      case (state_q)
         IDLE, FLUSH: begin
            if (sel_valid) begin
               if (!icache_busy) begin
                  issue = 1'b1;
               end else begin
                  state_d     = HOLD;
                  cnt_d       = '0;
                  pend_pc_d   = sel_pc;
                  pend_prio_d = sel_prio;
               end
            end else if (state_q == FLUSH) begin
               if (cnt_q <= CNT_W'(1)) begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
         end
         HOLD: begin
            take_new = sel_valid & prio_beats(sel_prio, pend_prio_q);
            if (!icache_busy) begin
               issue    = 1'b1;
               issue_pc = take_new ? sel_pc : pend_pc_q;
            end else if (take_new) begin
               pend_pc_d   = sel_pc;
               pend_prio_d = sel_prio;
            end
         end
         default: state_d = IDLE;
      endcase

      if (issue) begin
         state_d     = FLUSH;
         cnt_d       = CNT_INIT;
         pend_pc_d   = '0;
         pend_prio_d = '0;
      end

      // Reset cycle: nothing issues and any parked redirect is discarded.
      if (!rst_n) begin
         state_d     = IDLE;
         cnt_d       = '0;
         pend_pc_d   = '0;
         pend_prio_d = '0;
         issue       = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         pend_pc_q   <= '0;
         pend_prio_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         pend_pc_q   <= pend_pc_d;
         pend_prio_q <= pend_prio_d;
      end
   end

   assign load_we = issue;
   assign load_pc = issue ? {issue_pc[PC_W-1:2], 2'b00} : '0;
   assign flush   = rst_n & (state_q == FLUSH);
   assign pending = rst_n & (state_q == HOLD);
   assign stall   = (hz_stall | pending) & ~load_we;

`ifdef REDIRECT_PERF_EN
   logic drop;

   assign drop = rst_n & (((state_q == HOLD) & sel_valid & ~prio_beats(sel_prio, pend_prio_q)) |
                          ((state_q == FLUSH) & pred_valid));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         redirect_cnt <= '0;
         drop_cnt     <= '0;
      end else begin
         if (load_we) redirect_cnt <= redirect_cnt + 32'd1;
         if (drop)    drop_cnt     <= drop_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_redirect_arbiter.sv
module tb_fetch_redirect_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        exc_valid, mispred_valid, pred_valid;
   logic [31:0] exc_pc, mispred_pc, pred_pc;
   logic        icache_busy, hz_stall;

   logic        we1, st1, fl1, pd1;
   logic [31:0] pc1;
   logic        we3, st3, fl3, pd3;
   logic [31:0] pc3;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   fetch_redirect_arbiter #(.FLUSH_CYCLES(1), .PC_W(32)) u1 (
      .clk(clk), .rst_n(rst_n),
      .exc_valid(exc_valid), .exc_pc(exc_pc),
      .mispred_valid(mispred_valid), .mispred_pc(mispred_pc),
      .pred_valid(pred_valid), .pred_pc(pred_pc),
      .icache_busy(icache_busy), .hz_stall(hz_stall),
      .load_we(we1), .load_pc(pc1), .stall(st1), .flush(fl1), .pending(pd1)
   );

   fetch_redirect_arbiter #(.FLUSH_CYCLES(3), .PC_W(32)) u3 (
      .clk(clk), .rst_n(rst_n),
      .exc_valid(exc_valid), .exc_pc(exc_pc),
      .mispred_valid(mispred_valid), .mispred_pc(mispred_pc),
      .pred_valid(pred_valid), .pred_pc(pred_pc),
      .icache_busy(icache_busy), .hz_stall(hz_stall),
      .load_we(we3), .load_pc(pc3), .stall(st3), .flush(fl3), .pending(pd3)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: one record per instance (index 0 -> FLUSH_CYCLES=1, 1 -> 3).
   // mode: 0 nothing outstanding, 1 redirect parked, 2 squashing.
   int          fcs[2]     = '{1, 3};
   int          m_mode[2]  = '{0, 0};
   logic [31:0] m_ppc[2]   = '{32'h0, 32'h0};
   int          m_pprio[2] = '{0, 0};
   int          m_left[2]  = '{0, 0};

   bit          rv[3];
   logic [31:0] rp[3];
   int          best, cprio;
   logic [31:0] cpc;
   bit          e_we, e_fl, e_pd, e_st;
   logic [31:0] e_pc;
   bit          a_we, a_fl, a_pd, a_st;
   logic [31:0] a_pc;

   always @(negedge clk) begin
      rv = '{exc_valid, mispred_valid, pred_valid};
      rp = '{exc_pc, mispred_pc, pred_pc};
      for (int i = 0; i < 2; i++) begin
         best = -1;
         for (int k = 0; k < 3; k++)
            if (rv[k] && best < 0 && !(m_mode[i] == 2 && k == 2)) best = k;
         e_we = 0;
         e_pc = 0;
         e_fl = rst_n && m_mode[i] == 2;
         e_pd = rst_n && m_mode[i] == 1;
         if (!rst_n) begin
            m_mode[i] = 0; m_ppc[i] = 0; m_pprio[i] = 0; m_left[i] = 0;
         end else if (m_mode[i] == 1) begin
            cpc = m_ppc[i];
            cprio = m_pprio[i];
            if (best >= 0 && best < cprio) begin
               cpc = rp[best];
               cprio = best;
            end
            if (!icache_busy) begin
               e_we = 1; e_pc = cpc;
            end else begin
               m_ppc[i] = cpc; m_pprio[i] = cprio;
            end
         end else if (best >= 0) begin
            if (!icache_busy) begin
               e_we = 1; e_pc = rp[best];
            end else begin
               m_mode[i] = 1; m_ppc[i] = rp[best]; m_pprio[i] = best;
            end
         end else if (m_mode[i] == 2) begin
            m_left[i]--;
            if (m_left[i] == 0) m_mode[i] = 0;
         end
         if (e_we) begin
            m_mode[i] = 2;
            m_left[i] = fcs[i];
            e_pc = e_pc & 32'hFFFF_FFFC;
         end
         e_st = (hz_stall || e_pd) && !e_we;

         a_we = (i == 0) ? we1 : we3;
         a_pc = (i == 0) ? pc1 : pc3;
         a_fl = (i == 0) ? fl1 : fl3;
         a_pd = (i == 0) ? pd1 : pd3;
         a_st = (i == 0) ? st1 : st3;
         chk($sformatf("model u%0d load_we", fcs[i]), 32'(a_we), 32'(e_we));
         chk($sformatf("model u%0d load_pc", fcs[i]), a_pc, e_pc);
         chk($sformatf("model u%0d flush", fcs[i]), 32'(a_fl), 32'(e_fl));
         chk($sformatf("model u%0d pending", fcs[i]), 32'(a_pd), 32'(e_pd));
         chk($sformatf("model u%0d stall", fcs[i]), 32'(a_st), 32'(e_st));
      end
   end

   task automatic drive(input logic ev, input logic [31:0] ep,
                        input logic mv, input logic [31:0] mp,
                        input logic pv, input logic [31:0] pp,
                        input logic b, input logic h);
      @(posedge clk);
      #1;
      exc_valid = ev;     exc_pc = ep;
      mispred_valid = mv; mispred_pc = mp;
      pred_valid = pv;    pred_pc = pp;
      icache_busy = b;    hz_stall = h;
      #2;
   endtask

   task automatic idle(input int n);
      for (int j = 0; j < n; j++) drive(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      rst_n = 0;
      exc_valid = 0; mispred_valid = 0; pred_valid = 0;
      exc_pc = 0; mispred_pc = 0; pred_pc = 0;
      icache_busy = 0; hz_stall = 1;

      // Reset state, with a request present that must not issue
      drive(0, 0, 1, 32'h44, 0, 0, 0, 1);
      chk("rst load_we", 32'(we1), 0);
      chk("rst load_pc", pc1, 0);
      chk("rst stall", 32'(st1), 1);
      chk("rst flush", 32'(fl1), 0);
      chk("rst pending", 32'(pd3), 0);
      rst_n = 1;
      idle(2);

      // Zero-latency mispredict issue, then flush timing for 1 and 3
      drive(0, 0, 1, 32'h40, 0, 0, 0, 0);
      chk("mis we", 32'(we1), 1);
      chk("mis pc", pc1, 32'h40);
      chk("mis flush same cycle", 32'(fl1), 0);
      idle(1);
      chk("mis flush1", 32'(fl1), 1);
      chk("mis we after", 32'(we1), 0);
      idle(1);
      chk("mis idle u1", 32'(fl1), 0);
      chk("mis flush2 u3", 32'(fl3), 1);
      idle(1);
      chk("mis flush3 u3", 32'(fl3), 1);
      idle(1);
      chk("mis idle u3", 32'(fl3), 0);

      // exc beats pred in same cycle
      drive(1, 32'h180, 0, 0, 1, 32'h200, 0, 0);
      chk("exc vs pred u1", pc1, 32'h180);
      chk("exc vs pred u3", pc3, 32'h180);
      idle(3);

      // Busy icache: park pred, upgrade to mispred, issue once on release
      drive(0, 0, 0, 0, 1, 32'h100, 1, 0);
      chk("busy1 we", 32'(we1), 0);
      drive(0, 0, 1, 32'h300, 1, 32'h100, 1, 0);
      chk("busy2 pending", 32'(pd1), 1);
      chk("busy2 stall", 32'(st1), 1);
      drive(0, 0, 0, 0, 1, 32'h100, 1, 0);
      chk("busy3 pending", 32'(pd1), 1);
      chk("busy3 stall", 32'(st1), 1);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      chk("release we", 32'(we1), 1);
      chk("release pc", pc1, 32'h300);
      chk("release stall", 32'(st1), 0);
      idle(1);
      chk("release once", 32'(we1), 0);
      idle(2);

      // FLUSH_CYCLES=3: pred ignored mid-flush, exc reissues and re-arms flush
      drive(0, 0, 0, 0, 1, 32'h500, 0, 0);
      chk("f3 first pc", pc3, 32'h500);
      drive(0, 0, 0, 0, 1, 32'h600, 0, 0);
      chk("f3 pred ignored", 32'(we3), 0);
      chk("f3 flush c1", 32'(fl3), 1);
      drive(1, 32'h700, 0, 0, 0, 0, 0, 0);
      chk("f3 exc we", 32'(we3), 1);
      chk("f3 exc pc", pc3, 32'h700);
      chk("f3 exc flush", 32'(fl3), 1);
      idle(1); chk("f3 hold1", 32'(fl3), 1);
      idle(1); chk("f3 hold2", 32'(fl3), 1);
      idle(1); chk("f3 hold3", 32'(fl3), 1);
      idle(1); chk("f3 done", 32'(fl3), 0);

      // Reset while a redirect is parked
      drive(0, 0, 1, 32'h800, 0, 0, 1, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      rst_n = 0;
      #1;
      chk("rsthold we", 32'(we1), 0);
      chk("rsthold pending", 32'(pd1), 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      rst_n = 1;
      #1;
      chk("rsthold after pending", 32'(pd1), 0);
      chk("rsthold after we", 32'(we1), 0);
      chk("rsthold after we u3", 32'(we3), 0);
      idle(1);
      chk("rsthold later we", 32'(we1), 0);

      // Hazard stall vs issue, low PC bits forced to zero
      drive(0, 0, 1, 32'h43, 0, 0, 0, 1);
      chk("hz we", 32'(we1), 1);
      chk("hz stall", 32'(st1), 0);
      chk("hz pc", pc1, 32'h40);
      drive(0, 0, 0, 0, 0, 0, 0, 1);
      chk("hz stall next", 32'(st1), 1);
      idle(3);

      // Strictly higher request overrides parked one on release
      drive(0, 0, 1, 32'h1000, 0, 0, 1, 0);
      drive(1, 32'h2000, 0, 0, 0, 0, 0, 0);
      chk("override pc", pc1, 32'h2000);
      idle(3);

      // Equal priority does not replace parked entry
      drive(0, 0, 1, 32'h3000, 0, 0, 1, 0);
      drive(0, 0, 1, 32'h4000, 0, 0, 1, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      chk("equal keeps pc", pc1, 32'h3000);
      idle(3);

      // Broad mixed traffic, checked by the model every cycle
      for (int n = 0; n < 400; n++) begin
         @(posedge clk);
         #1;
         rst_n         = ($urandom_range(0, 60) != 0);
         exc_valid     = ($urandom_range(0, 7) == 0);
         mispred_valid = ($urandom_range(0, 4) == 0);
         pred_valid    = ($urandom_range(0, 2) == 0);
         exc_pc        = $urandom;
         mispred_pc    = $urandom;
         pred_pc       = $urandom;
         icache_busy   = ($urandom_range(0, 2) == 0);
         hz_stall      = ($urandom_range(0, 3) == 0);
      end
      rst_n = 1;
      idle(5);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
